// File: rtl/coleco_sgm_pkg.sv
// Shared constants and region decode helpers for the SGM-style expansion glue.
package coleco_sgm_pkg;

  // I/O port map (Z80 A7..A0)
  localparam logic [7:0] AY_ADDR_PORT = 8'h50;
  localparam logic [7:0] AY_DATA_PORT = 8'h51;
  localparam logic [7:0] AY_READ_PORT = 8'h52;
  localparam logic [7:0] RAM_EN_PORT  = 8'h53;
  localparam logic [7:0] BIOS_PORT    = 8'h7F;

  // 8 KB memory regions (Z80 A15..A13)
  localparam logic [2:0] REG_BIOS     = 3'b000;
  localparam logic       REG_CART_MSB = 1'b1;

  typedef enum logic [1:0] {
    REGION_BIOS_MAP = 2'd0,
    REGION_EXP_RAM  = 2'd1,
    REGION_CART     = 2'd2
  } region_e;

  // Classify an 8 KB region by its upper address bits.
  function automatic region_e classify_region(input logic [2:0] region);
    region_e cls;
    if (region[2] == REG_CART_MSB) begin
      cls = REGION_CART;
    end else if (region == REG_BIOS) begin
      cls = REGION_BIOS_MAP;
    end else begin
      cls = REGION_EXP_RAM;
    end
    return cls;
  endfunction

  // Expansion RAM answers in the BIOS window only when the BIOS is replaced,
  // and in the low 24 KB window only when expansion RAM is enabled.
  function automatic logic region_ram_hit(input logic [2:0] region,
                                          input logic       ram_en,
                                          input logic       bios_dis);
    logic hit;
    case (classify_region(region))
      REGION_BIOS_MAP: hit = bios_dis;
      REGION_EXP_RAM:  hit = ram_en;
      REGION_CART:     hit = 1'b0;
      default:         hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/coleco_sgm_regs.sv
// CPU-writable mode bits: expansion-RAM enable and BIOS replace.
module coleco_sgm_regs
  import coleco_sgm_pkg::*;
(
  input  logic       clk,
  input  logic       RESET,
  input  logic       io_wr,
  input  logic [7:0] port,
  input  logic [1:0] d_bits,
  output logic       ram_en,
  output logic       bios_dis
);

  logic ram_en_r;
  logic bios_dis_r;

  // Capture mode bits on I/O writes; a held write simply rewrites the same value.
  always_ff @(posedge clk) begin
    if (RESET) begin
      ram_en_r   <= 1'b0;
      bios_dis_r <= 1'b0;
    end else if (io_wr) begin
      if (port == RAM_EN_PORT) begin
        ram_en_r <= d_bits[0];
      end else begin
        ram_en_r <= ram_en_r;
      end
      // Bit 1 low maps RAM over the BIOS.
      if (port == BIOS_PORT) begin
        bios_dis_r <= ~d_bits[1];
      end else begin
        bios_dis_r <= bios_dis_r;
      end
    end else begin
      ram_en_r   <= ram_en_r;
      bios_dis_r <= bios_dis_r;
    end
  end

  assign ram_en   = ram_en_r;
  assign bios_dis = bios_dis_r;

endmodule

// File: rtl/coleco_sgm_glue.sv
// Bus decode for the SGM-style expansion board: SRAM select, AY-3-8910 select,
// and host memory disable. Decode is combinational so selects track the bus
// with zero latency; only the mode bits are registered.
module coleco_sgm_glue
  import coleco_sgm_pkg::*;
(
  input  logic        clk,
  input  logic        RESET,
  input  logic [10:0] A,
  input  logic        MREQn,
  input  logic        RFSHn,
  input  logic        IORQn,
  input  logic        WRn,
  input  logic        RDn,
  inout  wire  [7:0]  D,
  output logic        RAM_CSn,
  output logic        RAM_OEn,
  output logic        AY_CSn,
  output logic        AY_AS,
  output logic        DIS_MEM
);

  logic io_wr_s;
  logic io_rd_s;
  logic ram_en_s;
  logic bios_dis_s;
  logic unused_d_s;

  // The data bus is only sampled (low two bits); the board never drives it.
  assign unused_d_s = ^D[7:2];

  // I/O strobes; a simultaneous RD and WR is treated as a write only.
  always_comb begin
    io_wr_s = ~IORQn & ~WRn;
    io_rd_s = ~IORQn & ~RDn & ~io_wr_s;
  end

  coleco_sgm_regs u_regs (
    .clk      (clk),
    .RESET    (RESET),
    .io_wr    (io_wr_s),
    .port     (A[7:0]),
    .d_bits   (D[1:0]),
    .ram_en   (ram_en_s),
    .bios_dis (bios_dis_s)
  );

  logic mem_s;
  logic ram_sel_s;
  logic ay_sel_s;

  // Memory and AY decode; reset forces every select inactive regardless of the bus.
  always_comb begin
    mem_s     = ~MREQn & RFSHn;
    ram_sel_s = 1'b0;
    ay_sel_s  = 1'b0;
    RAM_CSn   = 1'b1;
    RAM_OEn   = 1'b1;
    AY_CSn    = 1'b1;
    AY_AS     = 1'b0;
    DIS_MEM   = 1'b0;
    if (RESET) begin
      ram_sel_s = 1'b0;
      ay_sel_s  = 1'b0;
    end else begin
      ram_sel_s = mem_s & region_ram_hit(A[10:8], ram_en_s, bios_dis_s);
      ay_sel_s  = (io_wr_s & ((A[7:0] == AY_ADDR_PORT) | (A[7:0] == AY_DATA_PORT)))
                | (io_rd_s & (A[7:0] == AY_READ_PORT));
      RAM_CSn   = ~ram_sel_s;
      RAM_OEn   = ~ram_sel_s | RDn;
      AY_CSn    = ~ay_sel_s;
      AY_AS     = ay_sel_s & (A[7:0] == AY_ADDR_PORT);
      DIS_MEM   = ram_sel_s;
    end
  end

endmodule

// File: tb/tb_coleco_sgm_glue.sv
// Self-checking bench for coleco_sgm_glue: directed table, AY sweeps, and
// randomized bus traffic against a behavioural model of the board.
module tb_coleco_sgm_glue;

  logic        clk = 1'b0;
  logic        RESET;
  logic [10:0] A;
  logic        MREQn, RFSHn, IORQn, WRn, RDn;
  logic [7:0]  d_drv;
  wire  [7:0]  d_bus;
  logic        RAM_CSn, RAM_OEn, AY_CSn, AY_AS, DIS_MEM;

  assign d_bus = d_drv;

  coleco_sgm_glue dut (
    .clk     (clk),
    .RESET   (RESET),
    .A       (A),
    .MREQn   (MREQn),
    .RFSHn   (RFSHn),
    .IORQn   (IORQn),
    .WRn     (WRn),
    .RDn     (RDn),
    .D       (d_bus),
    .RAM_CSn (RAM_CSn),
    .RAM_OEn (RAM_OEn),
    .AY_CSn  (AY_CSn),
    .AY_AS   (AY_AS),
    .DIS_MEM (DIS_MEM)
  );

  always #5 clk = ~clk;

  // Output vector order: {RAM_CSn, RAM_OEn, AY_CSn, AY_AS, DIS_MEM}
  typedef struct {
    string       name;
    logic        rst;
    logic [10:0] a;
    logic        mreqn, rfshn, iorqn, wrn, rdn;
    logic [7:0]  d;
    logic [4:0]  exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  // Model state: the two mode bits as the board should hold them.
  bit m_ram_en   = 1'b0;
  bit m_bios_dis = 1'b0;

  localparam logic [4:0] IDLE = 5'b11100;

  function automatic vec_t mk(string name, logic rst, logic [10:0] a,
                              logic mreqn, logic rfshn, logic iorqn,
                              logic wrn, logic rdn, logic [7:0] d, logic [4:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.a = a; v.mreqn = mreqn; v.rfshn = rfshn;
    v.iorqn = iorqn; v.wrn = wrn; v.rdn = rdn; v.d = d; v.exp = exp;
    return v;
  endfunction

  // Behavioural expectation from the board's documented rules.
  function automatic logic [4:0] model(vec_t v);
    int  region;
    int  port;
    bit  hit, sel, wr, rd, ay;
    if (v.rst) return IDLE;
    region = int'(v.a) / 256;
    port   = int'(v.a) % 256;
    if (region == 0)      hit = m_bios_dis;
    else if (region <= 3) hit = m_ram_en;
    else                  hit = 1'b0;
    sel = (v.mreqn == 1'b0) && (v.rfshn == 1'b1) && hit;
    wr  = (v.iorqn == 1'b0) && (v.wrn == 1'b0);
    rd  = (v.iorqn == 1'b0) && (v.rdn == 1'b0) && !wr;
    ay  = (wr && (port == 'h50 || port == 'h51)) || (rd && port == 'h52);
    return {!sel, !(sel && v.rdn == 1'b0), !ay, ay && port == 'h50, sel};
  endfunction

  task automatic check(string name, logic [4:0] act, logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {cs,oe,ay,as,dis}=%b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one bus cycle, check mid-cycle, then advance the model across the edge.
  task automatic step(vec_t v);
    int port;
    RESET = v.rst; A = v.a; MREQn = v.mreqn; RFSHn = v.rfshn;
    IORQn = v.iorqn; WRn = v.wrn; RDn = v.rdn; d_drv = v.d;
    #4;
    check(v.name, {RAM_CSn, RAM_OEn, AY_CSn, AY_AS, DIS_MEM}, v.exp);
    @(posedge clk);
    port = int'(v.a) % 256;
    if (v.rst) begin
      m_ram_en = 1'b0; m_bios_dis = 1'b0;
    end else if (v.iorqn == 1'b0 && v.wrn == 1'b0) begin
      if (port == 'h53) m_ram_en = v.d[0];
      if (port == 'h7F) m_bios_dis = !v.d[1];
    end
    #1;
  endtask

  vec_t tbl[20];

  initial begin
    RESET = 1'b1; A = 11'h000; MREQn = 1'b1; RFSHn = 1'b1;
    IORQn = 1'b1; WRn = 1'b1; RDn = 1'b1; d_drv = 8'h00;

    //            name          rst   A        mrq   rfsh  iorq  wr    rd    D      {cs,oe,ay,as,dis}
    tbl[0]  = mk("reset_hold",  1'b1, 11'h050, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'b11100);
    tbl[1]  = mk("wr_ram_en",   1'b0, 11'h053, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 5'b11100);
    tbl[2]  = mk("ram_rd_r1",   1'b0, 11'h100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b00101);
    tbl[3]  = mk("ram_rd_r2",   1'b0, 11'h200, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b00101);
    tbl[4]  = mk("ram_rd_r3",   1'b0, 11'h300, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b00101);
    tbl[5]  = mk("refresh_r3",  1'b0, 11'h300, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 5'b11100);
    tbl[6]  = mk("cart_r4",     1'b0, 11'h400, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b11100);
    tbl[7]  = mk("bios_off_r0", 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b11100);
    tbl[8]  = mk("wr_bios_00",  1'b0, 11'h07F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 5'b11100);
    tbl[9]  = mk("bios_rd_r0",  1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b00101);
    tbl[10] = mk("bios_wr_r0",  1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 5'b01101);
    tbl[11] = mk("wr_bios_02",  1'b0, 11'h07F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 5'b11100);
    tbl[12] = mk("bios_back",   1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b11100);
    tbl[13] = mk("ay_addr_hi",  1'b0, 11'h750, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0E, 5'b11010);
    tbl[14] = mk("ay_read",     1'b0, 11'h052, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 5'b11000);
    tbl[15] = mk("rdwr_52",     1'b0, 11'h052, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'b11100);
    tbl[16] = mk("rdwr_51",     1'b0, 11'h051, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'b11000);
    tbl[17] = mk("pre_midrst",  1'b0, 11'h100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b00101);
    tbl[18] = mk("midrst",      1'b1, 11'h100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b11100);
    tbl[19] = mk("post_midrst", 1'b0, 11'h100, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b11100);

    @(posedge clk);
    #1;

    // Reset, then default map: nothing answers in any region.
    step(tbl[0]);
    for (int r = 0; r < 8; r++) begin
      step(mk("default_map", 1'b0, 11'(r * 256), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b11100));
    end

    // Directed table.
    for (int i = 0; i < 20; i++) step(tbl[i]);

    // Write sweep over all ports with D=0: only 0x50/0x51 select the AY.
    // Side effect: 0x53 clears ram_en, 0x7F with bit1=0 sets bios_dis.
    for (int p = 0; p < 256; p++) begin
      logic [4:0] e;
      e = {1'b1, 1'b1, !(p == 'h50 || p == 'h51), (p == 'h50), 1'b0};
      step(mk("ay_wr_sweep", 1'b0, 11'(p), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, e));
    end
    step(mk("sweep_bios",  1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b00101));
    step(mk("sweep_ramen", 1'b0, 11'h200, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b11100));

    // Read sweep: only 0x52 selects; no register may change.
    for (int p = 0; p < 256; p++) begin
      logic [4:0] e;
      e = {1'b1, 1'b1, !(p == 'h52), 1'b0, 1'b0};
      step(mk("ay_rd_sweep", 1'b0, 11'(p), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, e));
    end
    step(mk("rdsweep_bios", 1'b0, 11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 5'b00101));

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      int   pick;
      logic [7:0] port;
      pick = int'($urandom_range(0, 7));
      case (pick)
        0: port = 8'h50;
        1: port = 8'h51;
        2: port = 8'h52;
        3: port = 8'h53;
        4: port = 8'h7F;
        default: port = 8'($urandom);
      endcase
      v.name  = "random";
      v.rst   = ($urandom_range(0, 39) == 0);
      v.a     = {3'($urandom), port};
      v.mreqn = 1'($urandom);
      v.rfshn = ($urandom_range(0, 3) != 0);
      v.iorqn = 1'($urandom);
      v.wrn   = 1'($urandom);
      v.rdn   = 1'($urandom);
      v.d     = 8'($urandom);
      v.exp   = model(v);
      step(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coleco_sgm_glue.md
Name: coleco_sgm_glue

Overview:
- Glue logic for a ColecoVision Super-Game-Module-style expansion board.
- Decodes Z80 memory and I/O cycles to select the expansion SRAM and the AY-3-8910 sound chip.
- Holds two mode bits written by the CPU: expansion-RAM enable and BIOS replace.
- Asserts DIS_MEM so the host console's own BIOS/RAM stays off the bus whenever expansion RAM answers.

Parameters:
- AY_ADDR_PORT, 8'h50, I/O port that latches the AY register address (write).
- AY_DATA_PORT, 8'h51, I/O port for AY data write.
- AY_READ_PORT, 8'h52, I/O port for AY data read.
- RAM_EN_PORT, 8'h53, I/O port for the expansion-RAM enable register; bit 0 is used.
- BIOS_PORT, 8'h7F, I/O port for the BIOS-replace register; bit 1 is used.

Ports:
- clk  in  1  CPU-rate clock (~3.58 MHz).
- RESET  in  1  synchronous reset, active-high.
- A  in  11  A[7:0] = Z80 A7..A0 (I/O port); A[10:8] = Z80 A15..A13 (8 KB memory region).
- MREQn  in  1  Z80 memory request, active-low.
- RFSHn  in  1  Z80 refresh, active-low.
- IORQn  in  1  Z80 I/O request, active-low.
- WRn  in  1  Z80 write strobe, active-low.
- RDn  in  1  Z80 read strobe, active-low.
- D  inout  8  Z80 data bus. The block samples it and never drives it (always high-Z).
- RAM_CSn  out  1  expansion SRAM chip select, active-low.
- RAM_OEn  out  1  expansion SRAM output enable, active-low.
- AY_CSn  out  1  AY chip select, active-low.
- AY_AS  out  1  AY address-latch select (1 = address cycle, 0 = data cycle).
- DIS_MEM  out  1  active-high; disables host BIOS/RAM decode.

Behaviour:
- State registers: ram_en and bios_dis, both cleared when RESET is sampled high on a rising clk edge.
- io_wr = ~IORQn & ~WRn; io_rd = ~IORQn & ~RDn.
- On a rising clk edge with RESET low and io_wr:
  - A[7:0]==RAM_EN_PORT: ram_en <= D[0].
  - A[7:0]==BIOS_PORT: bios_dis <= ~D[1]. Bit 1 = 0 maps RAM over the BIOS, matching SGM convention.
- A write held for several cycles simply rewrites the same value. Writes to any other port leave both registers unchanged.
- mem = ~MREQn & RFSHn. Refresh cycles never select RAM.
- ram_hit is decided by region A[10:8]:
  - 000: hit when bios_dis.
  - 001, 010, 011: hit when ram_en.
  - 1xx (cartridge): never a hit.
- Decode outputs are combinational from the bus and registers, with zero latency. A register write takes effect on the cycle after the capturing edge.
- RAM_CSn = ~(mem & ram_hit).
- RAM_OEn = RAM_CSn | RDn.
- DIS_MEM = mem & ram_hit.
- AY_CSn = ~( io_wr & (A==AY_ADDR_PORT | A==AY_DATA_PORT) | io_rd & A==AY_READ_PORT ). The compare uses A[7:0]; A[10:8] are ignored for I/O.
- AY_AS = 1 iff ~AY_CSn & A[7:0]==AY_ADDR_PORT, else 0.
- RD and WR asserted together during IORQ: treated as a write, and AY_READ_PORT is not selected.
- While RESET is high:
  - RAM_CSn=1, RAM_OEn=1, AY_CSn=1, AY_AS=0, DIS_MEM=0, regardless of bus state.
  - Register writes are ignored.
- Reset asserted mid-operation drops all selects immediately.

Decomposition:
- Package coleco_sgm_pkg holds the port address constants and region encodings: REG_BIOS=3'b000, REG_CART_MSB=1.
- One sub-module, coleco_sgm_regs, holds the two registers and their write logic. The top level holds the combinational decode.

Test Plan:
- Reset: hold RESET=1, MREQn=0, RFSHn=1, A[10:8]=000, IORQn=0, WRn=0, A[7:0]=0x50 → all selects high, AY_AS=0, DIS_MEM=0.
- Default map: after reset, MREQn=0, RFSHn=1, A[10:8] stepping 000..111 with RDn=0 → RAM_CSn=1 and DIS_MEM=0 for every region.
- RAM enable:
  - Write D=0x01 to 0x53, then read A[10:8]=001, 010, 011 → RAM_CSn=0, RAM_OEn=0, DIS_MEM=1.
  - Same cycle with RFSHn=0 → RAM_CSn=1.
  - A[10:8]=100 → RAM_CSn=1.
- BIOS replace: write D=0x00 to 0x7F, then A[10:8]=000 → RAM_CSn=0. Write D=0x02 to 0x7F → RAM_CSn=1.
- AY sweep, IORQn=0:
  - Write strobe over A[7:0]=0x00..0xFF → AY_CSn=0 only at 0x50 (AY_AS=1) and 0x51 (AY_AS=0).
  - Read strobe over the same range → AY_CSn=0 only at 0x52.
  - No change to ram_en or bios_dis except on writes to 0x53 and 0x7F.
- Mid-op reset: ram_en=1 with RAM_CSn=0, pulse RESET for one cycle → RAM_CSn=1 immediately, and stays 1 afterwards (ram_en cleared).
